act_pwl_int16: RTL and testbench



---
 rtl/nn_act_pkg.sv | 26 ++
 rtl/act_seg_table.sv | 43 ++++
 rtl/act_pwl_int16.sv | 93 +++++++++
 tb/tb_act_pwl_int16.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_act_pkg.sv
// Shared types and helpers for the neuron-unit activation stage.
// Codes are offset binary: 0x0000 = -1024.0, 0x8000 = 0.0, LSB = 1/32.
package nn_act_pkg;

  localparam int          CODE_W    = 16;
  localparam logic [15:0] CODE_ZERO = 16'h8000;

  typedef struct packed {
    logic        [15:0] base;
    logic signed [15:0] slope;
  } seg_entry_t;

  // Saturate a signed 18-bit sum into the unsigned 16-bit output range.
  function automatic logic [15:0] sat_u16(input logic signed [17:0] val);
    logic [15:0] res;
    if (val < 18'sd0) begin
      res = 16'h0000;
    end else if (val > 18'sd65535) begin
      res = 16'hFFFF;
    end else begin
      res = val[15:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/act_seg_table.sv
// Segment table: register array with one write port and a registered,
// enable-gated read port. A read and write to one address on the same edge
// returns the old entry.
module act_seg_table
  import nn_act_pkg::*;
#(
  parameter int SEG_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [SEG_BITS-1:0] waddr,
  input  logic [31:0]         wdata,
  input  logic                rd_en,
  input  logic [SEG_BITS-1:0] raddr,
  output logic [31:0]         rdata
);

  localparam int DEPTH = 1 << SEG_BITS;

  seg_entry_t mem_r [DEPTH];
  seg_entry_t rdata_r;

  // Table storage and registered read; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rdata_r <= '0;
    end else begin
      if (we) begin
        mem_r[waddr] <= seg_entry_t'(wdata);
      end
      if (rd_en) begin
        rdata_r <= mem_r[raddr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/act_pwl_int16.sv
// Piecewise-linear activation on offset-binary int16 codes: table read,
// slope multiply, base add with saturation. Three stages, one global stall.
module act_pwl_int16
  import nn_act_pkg::*;
#(
  parameter int SEG_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data,
  input  logic                tbl_we,
  input  logic [SEG_BITS-1:0] tbl_addr,
  input  logic [15:0]         tbl_base,
  input  logic [15:0]         tbl_slope,
  output logic                busy
);

  localparam int F  = CODE_W - SEG_BITS;
  localparam int PW = 17 + F;

  logic                 adv_s;
  logic                 accept_s;
  logic [31:0]          rd_s;
  seg_entry_t           ent1_s;
  logic signed [PW-1:0] prod_s;
  logic signed [17:0]   sum_s;

  logic                 v1_r;
  logic                 v2_r;
  logic                 v3_r;
  logic [F-1:0]         frac1_r;
  logic signed [PW-1:0] prod2_r;
  logic [15:0]          base2_r;
  logic [15:0]          out_data_r;

  act_seg_table #(.SEG_BITS(SEG_BITS)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata ({tbl_base, tbl_slope}),
    .rd_en (accept_s),
    .raddr (in_code[CODE_W-1:F]),
    .rdata (rd_s)
  );

  // Stall control plus stage-2 multiply and stage-3 add (floor shift of prod).
  always_comb begin
    adv_s    = !v3_r || out_ready;
    accept_s = in_valid && adv_s;
    ent1_s   = seg_entry_t'(rd_s);
    prod_s   = $signed(ent1_s.slope) * $signed({1'b0, frac1_r});
    sum_s    = $signed({2'b00, base2_r}) + $signed(18'(prod2_r >>> F));
  end

  // Pipeline registers; everything holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r       <= 1'b0;
      v2_r       <= 1'b0;
      v3_r       <= 1'b0;
      frac1_r    <= '0;
      prod2_r    <= '0;
      base2_r    <= 16'h0000;
      out_data_r <= 16'h0000;
    end else if (adv_s) begin
      v1_r <= in_valid;
      v2_r <= v1_r;
      v3_r <= v2_r;
      if (in_valid) begin
        frac1_r <= in_code[F-1:0];
      end
      if (v1_r) begin
        prod2_r <= prod_s;
        base2_r <= ent1_s.base;
      end
      if (v2_r) begin
        out_data_r <= sat_u16(sum_s);
      end
    end
  end

  assign in_ready  = adv_s;
  assign out_valid = v3_r;
  assign out_data  = out_data_r;
  assign busy      = v1_r | v2_r | v3_r;

endmodule

// File: tb/tb_act_pwl_int16.sv
// Self-checking bench for act_pwl_int16 against an arithmetic reference model.
module tb_act_pwl_int16;
  import nn_act_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_code = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        tbl_we = 1'b0;
  logic [5:0]  tbl_addr = 6'd0;
  logic [15:0] tbl_base = 16'h0000;
  logic [15:0] tbl_slope = 16'h0000;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int m_base [64];
  int m_slope [64];
  int exp_q [$];
  logic [15:0] in_q [$];
  logic [15:0] got_q [$];
  int gexp_q [$];

  logic        s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_out_data;

  act_pwl_int16 #(.SEG_BITS(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_base(tbl_base), .tbl_slope(tbl_slope), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: out = clamp(base + floor(slope * frac / 1024)), 64 segments.
  function automatic int model(input logic [15:0] code);
    int c, idx, frac, p, q, r;
    c    = code;
    idx  = c / 1024;
    frac = c % 1024;
    p    = m_slope[idx] * frac;
    q    = (p >= 0) ? (p / 1024) : -((-p + 1023) / 1024);
    r    = m_base[idx] + q;
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_base[i]  = 0;
      m_slope[i] = 0;
    end
    exp_q.delete();
  endtask

  // Drive one cycle from a negedge; sample just after, then advance a cycle.
  task automatic cycle(input logic v, input logic [15:0] code, input logic ordy,
                       input logic we, input int addr, input int base, input int slope,
                       output logic acc, output logic took, output logic [15:0] got,
                       output int exp);
    logic [15:0] sl;
    in_valid  = v;
    in_code   = code;
    out_ready = ordy;
    tbl_we    = we;
    tbl_addr  = addr[5:0];
    tbl_base  = base[15:0];
    tbl_slope = slope[15:0];
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_busy      = busy;
    acc  = v && in_ready;
    took = out_valid && ordy;
    got  = out_data;
    exp  = -1;
    if (took && exp_q.size() > 0) exp = exp_q.pop_front();
    if (acc) exp_q.push_back(model(code));
    if (we) begin
      sl = slope[15:0];
      m_base[addr]  = base & 32'h0000FFFF;
      m_slope[addr] = int'($signed(sl));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; tbl_we = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic write_entry(input int addr, input int base, input int slope);
    logic a, t; logic [15:0] g; int e;
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, addr, base, slope, a, t, g, e);
  endtask

  // Stream in_q with out_ready high and collect every delivered result.
  task automatic send_stream();
    logic a, t; logic [15:0] g; int e; int i;
    i = 0;
    got_q.delete();
    gexp_q.delete();
    for (int c = 0; c < 60 && (i < in_q.size() || exp_q.size() > 0); c++) begin
      if (i < in_q.size()) cycle(1'b1, in_q[i], 1'b1, 1'b0, 0, 0, 0, a, t, g, e);
      else                 cycle(1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 0, a, t, g, e);
      if (a) i++;
      if (t) begin
        got_q.push_back(g);
        gexp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_table();
    logic [15:0] codes [3];
    logic a, t; logic [15:0] g; int e;
    int first_acc, first_vld, n_out;
    codes[0] = 16'h0000; codes[1] = CODE_ZERO; codes[2] = 16'hFFFF;
    first_acc = -1; first_vld = -1; n_out = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) cycle(1'b1, codes[c], 1'b1, 1'b0, 0, 0, 0, a, t, g, e);
      else       cycle(1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 0, a, t, g, e);
      if (a && first_acc < 0) first_acc = c;
      if (s_out_valid && first_vld < 0) first_vld = c;
      if (first_acc >= 0 && c > first_acc && c <= first_acc + 5) begin
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL zero_busy: cycle %0d got %b want 1", c, s_busy); end
      end
      if (t) begin
        n_out++;
        checks++; if (g !== 16'h0000) begin errors++; $display("FAIL zero_data: got %h want 0000", g); end
      end
    end
    checks++; if (first_vld - first_acc !== 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", first_vld - first_acc); end
    checks++; if (n_out !== 3) begin errors++; $display("FAIL zero_count: got %0d want 3", n_out); end
  endtask

  task automatic test_linear();
    write_entry(32, 32'h8000, 32'h0400);
    in_q.delete(); in_q.push_back(16'h8000); in_q.push_back(16'h8200);
    send_stream();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL linear_count: got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'h8000) begin errors++; $display("FAIL linear_0: got %h want 8000", got_q[0]); end
      checks++; if (got_q[1] !== 16'h8200) begin errors++; $display("FAIL linear_1: got %h want 8200", got_q[1]); end
    end
  endtask

  task automatic test_clamp();
    write_entry(63, 32'hFFF0, 32'h0100);
    write_entry(0, 32'h0010, 32'hFF00);
    in_q.delete(); in_q.push_back(16'hFFFF); in_q.push_back(16'h03FF); in_q.push_back(16'h0000);
    send_stream();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL clamp_count: got %0d want 3", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'hFFFF) begin errors++; $display("FAIL clamp_upper: got %h want ffff", got_q[0]); end
      checks++; if (got_q[1] !== 16'h0000) begin errors++; $display("FAIL clamp_lower: got %h want 0000", got_q[1]); end
      checks++; if (got_q[2] !== 16'h0010) begin errors++; $display("FAIL clamp_base: got %h want 0010", got_q[2]); end
    end
  endtask

  task automatic test_backpressure();
    logic a, t, ordy, prev_stall; logic [15:0] g, prev_data; int e, sent, n_took;
    for (int i = 0; i < 64; i++) write_entry(i, $urandom_range(0, 65535), $urandom_range(0, 65535));
    sent = 0; n_took = 0; prev_stall = 1'b0; prev_data = 16'h0000;
    for (int c = 0; c < 60 && (sent < 8 || exp_q.size() > 0); c++) begin
      ordy = !(c >= 4 && c < 9);
      cycle(sent < 8, 16'($urandom_range(0, 65535)), ordy, 1'b0, 0, 0, 0, a, t, g, e);
      if (a) sent++;
      if (s_out_valid && !ordy) begin
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, s_in_ready); end
        if (prev_stall) begin
          checks++; if (s_out_data !== prev_data) begin errors++; $display("FAIL bp_hold: got %h want %h", s_out_data, prev_data); end
        end
      end
      prev_stall = s_out_valid && !ordy;
      prev_data  = s_out_data;
      if (t) begin
        n_took++;
        checks++; if (int'(g) !== e) begin errors++; $display("FAIL bp_data: got %h want %0d", g, e); end
      end
    end
    checks++; if (n_took !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", n_took); end
  endtask

  task automatic test_table_hazard();
    logic a, t; logic [15:0] g; int e;
    write_entry(32, 32'h8000, 32'h0400);
    cycle(1'b1, 16'h8200, 1'b1, 1'b1, 32, 32'h8000, 32'h0000, a, t, g, e);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL hazard_accept: got %b want 1", a); end
    in_q.delete(); in_q.push_back(16'h8200);
    send_stream();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL hazard_count: got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'h8200) begin errors++; $display("FAIL hazard_old: got %h want 8200", got_q[0]); end
      checks++; if (got_q[1] !== 16'h8000) begin errors++; $display("FAIL hazard_new: got %h want 8000", got_q[1]); end
    end
  endtask

  task automatic test_reset_midflight();
    logic a, t; logic [15:0] g; int e;
    write_entry(32, 32'h1234, 32'h0400);
    for (int c = 0; c < 3; c++) cycle(1'b1, 16'h8000, 1'b0, 1'b0, 0, 0, 0, a, t, g, e);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    do_reset(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 0, a, t, g, e);
      checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_output: cycle %0d got %b want 0", c, s_out_valid); end
    end
    in_q.delete(); in_q.push_back(16'h8000);
    send_stream();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_count: got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 16'h0000) begin errors++; $display("FAIL mid_cleared: got %h want 0000", got_q[0]); end
    end
  endtask

  task automatic test_random();
    logic a, t, v, ordy, we; logic [15:0] g, code; int e, addr;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      we   = ($urandom_range(0, 4) == 0);
      code = 16'($urandom_range(0, 65535));
      addr = ($urandom_range(0, 1) == 0) ? int'(code[15:10]) : $urandom_range(0, 63);
      cycle(v, code, ordy, we, addr, $urandom_range(0, 65535), $urandom_range(0, 65535), a, t, g, e);
      if (t) begin
        checks++; if (int'(g) !== e) begin errors++; $display("FAIL rand_data: cycle %0d got %h want %0d", c, g, e); end
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle(1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, 0, a, t, g, e);
      if (t) begin
        checks++; if (int'(g) !== e) begin errors++; $display("FAIL rand_drain: got %h want %0d", g, e); end
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_table();
    test_linear();
    test_clamp();
    test_backpressure();
    test_table_hazard();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
